tx_packet_buffer: RTL and testbench

Single-packet staging buffer directly upstream of the Ethernet TX controller. User logic writes a frame as 16-bit words and marks the last word. The buffer then holds `tx_req_out` high toward the TX controller and hands it one word per `tx_packet_data_rdy_in` pulse. It blocks new writes until the controller reports `tx_complete_in`.

---
 rtl/tx_packet_buffer.sv | 129 ++++++++++++
 tb/tb_tx_packet_buffer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/tx_packet_buffer.sv
// Single-frame staging buffer feeding the Ethernet TX controller one 16-bit word per request.
// Optional TXBUF_FRAME_CNT_EN adds a completed-frame counter output.
module tx_packet_buffer #(
  parameter int ADDR_W = 10
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        wr_en_in,
  input  logic [15:0] wr_data_in,
  input  logic        wr_last_in,
  output logic        wr_ready_out,
  output logic        tx_req_out,
  output logic [15:0] tx_packet_data_out,
  input  logic        tx_packet_data_rdy_in,
  input  logic        tx_complete_in,
  output logic        busy_out,
  output logic        err_overflow_out
`ifdef TXBUF_FRAME_CNT_EN
  ,
  output logic [15:0] frames_sent_out
`endif
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [15:0]       mem [DEPTH];
  logic [ADDR_W-1:0] wp;
  logic [ADDR_W-1:0] rp;
  logic [ADDR_W:0]   cnt;
  logic              full;
  logic              wr_accept;
  logic              wr_drop;
  logic              pop;
  logic              last_pop;
  logic              done;

  // cnt never exceeds DEPTH, so its top bit alone flags a full buffer
  assign full      = cnt[ADDR_W];
  assign wr_accept = (state == IDLE) && wr_en_in && !full;
  assign wr_drop   = (state == IDLE) && wr_en_in && full;
  assign pop       = (state == SEND) && tx_packet_data_rdy_in && (cnt != '0);
  assign last_pop  = pop && (cnt == (ADDR_W + 1)'(1));
  assign done      = (state == WAIT_DONE) && tx_complete_in;

  assign wr_ready_out = (state == IDLE);
  assign busy_out     = (state != IDLE);
  assign tx_req_out   = (state == SEND) && (cnt != '0);

  // state register
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (wr_en_in && wr_last_in) state_nxt = SEND;
        else                        state_nxt = IDLE;
      end
      SEND: begin
        if (last_pop) state_nxt = WAIT_DONE;
        else          state_nxt = SEND;
      end
      WAIT_DONE: begin
        if (tx_complete_in) state_nxt = IDLE;
        else                state_nxt = WAIT_DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // frame storage; asynchronous read so the pop edge sees RAM[rp] directly
  always_ff @(posedge Clock) begin
    if (wr_accept) begin
      mem[wp] <= wr_data_in;
    end
  end

  // pointers, occupancy, output word and overflow pulse
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      wp                 <= '0;
      rp                 <= '0;
      cnt                <= '0;
      tx_packet_data_out <= 16'h0000;
      err_overflow_out   <= 1'b0;
    end else begin
      err_overflow_out <= wr_drop;
      if (done) begin
        wp  <= '0;
        rp  <= '0;
        cnt <= '0;
      end else if (wr_accept) begin
        wp  <= wp + ADDR_W'(1);
        cnt <= cnt + (ADDR_W + 1)'(1);
      end else if (pop) begin
        tx_packet_data_out <= mem[rp];
        rp                 <= rp + ADDR_W'(1);
        cnt                <= cnt - (ADDR_W + 1)'(1);
      end
    end
  end

`ifdef TXBUF_FRAME_CNT_EN
  // completed-frame counter, wraps naturally at 16 bits
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      frames_sent_out <= 16'h0000;
    end else if (done) begin
      frames_sent_out <= frames_sent_out + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tx_packet_buffer.sv
// Randomized self-checking bench for tx_packet_buffer against a queue-based frame model.
module tb_tx_packet_buffer;

  localparam int ADDR_W = 2;
  localparam int DEPTH  = 4;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        wr_en_in = 1'b0;
  logic [15:0] wr_data_in = 16'h0000;
  logic        wr_last_in = 1'b0;
  logic        wr_ready_out;
  logic        tx_req_out;
  logic [15:0] tx_packet_data_out;
  logic        tx_packet_data_rdy_in = 1'b0;
  logic        tx_complete_in = 1'b0;
  logic        busy_out;
  logic        err_overflow_out;
`ifdef TXBUF_FRAME_CNT_EN
  logic [15:0] frames_sent_out;
`endif

  tx_packet_buffer #(.ADDR_W(ADDR_W)) dut (
    .Clock                 (Clock),
    .Reset                 (Reset),
    .wr_en_in              (wr_en_in),
    .wr_data_in            (wr_data_in),
    .wr_last_in            (wr_last_in),
    .wr_ready_out          (wr_ready_out),
    .tx_req_out            (tx_req_out),
    .tx_packet_data_out    (tx_packet_data_out),
    .tx_packet_data_rdy_in (tx_packet_data_rdy_in),
    .tx_complete_in        (tx_complete_in),
    .busy_out              (busy_out),
    .err_overflow_out      (err_overflow_out)
`ifdef TXBUF_FRAME_CNT_EN
    ,
    .frames_sent_out       (frames_sent_out)
`endif
  );

  always #5 Clock = ~Clock;

  int          tests = 0;
  int          fails = 0;
  logic [15:0] q[$];
  logic [15:0] frame_data [8];
  logic [15:0] last_data = 16'h0000;
  logic [15:0] frames = 16'h0000;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check_idle();
    check("idle_ready", wr_ready_out, 1);
    check("idle_busy", busy_out, 0);
    check("idle_req", tx_req_out, 0);
    check("idle_data", tx_packet_data_out, last_data);
  `ifdef TXBUF_FRAME_CNT_EN
    check("frames", frames_sent_out, frames);
  `endif
  endtask

  // writes frame_data[0..n-1] with last on word n-1; words past capacity are dropped
  task automatic write_frame(input int n);
    bit dropped;
    for (int i = 0; i < n; i++) begin
      wr_en_in   = 1'b1;
      wr_data_in = frame_data[i];
      wr_last_in = (i == n - 1);
      tick();
      dropped = (q.size() == DEPTH);
      if (!dropped) q.push_back(frame_data[i]);
      check("wr_ovf", err_overflow_out, dropped);
      check("wr_ready", wr_ready_out, (i == n - 1) ? 0 : 1);
      check("wr_req", tx_req_out, (i == n - 1) ? 1 : 0);
    end
    wr_en_in   = 1'b0;
    wr_last_in = 1'b0;
  endtask

  task automatic junk(input bit en);
    wr_en_in   = en & $urandom_range(0, 1);
    wr_last_in = $urandom_range(0, 1);
    wr_data_in = 16'($urandom);
  endtask

  // pops n words (n<0 means all) with random gaps and stray inputs in between
  task automatic drain(input int n, input int gap_max, input bit noise);
    int k = 0;
    while (q.size() > 0 && (n < 0 || k < n)) begin
      int gap = $urandom_range(0, gap_max);
      for (int g = 0; g < gap; g++) begin
        tx_packet_data_rdy_in = 1'b0;
        tx_complete_in = noise & $urandom_range(0, 1);
        junk(noise);
        tick();
        check("gap_req", tx_req_out, 1);
        check("gap_ovf", err_overflow_out, 0);
        check("gap_data", tx_packet_data_out, last_data);
      end
      tx_complete_in = 1'b0;
      tx_packet_data_rdy_in = 1'b1;
      junk(noise);
      tick();
      last_data = q.pop_front();
      k++;
      check("pop_data", tx_packet_data_out, last_data);
      check("pop_req", tx_req_out, (q.size() != 0) ? 1 : 0);
      check("pop_busy", busy_out, 1);
      check("pop_ovf", err_overflow_out, 0);
    end
    tx_packet_data_rdy_in = 1'b0;
    wr_en_in = 1'b0;
    wr_last_in = 1'b0;
  endtask

  // trailing pop must be ignored, then completion returns to idle
  task automatic finish_frame(input bit noise);
    tx_packet_data_rdy_in = 1'b1;
    junk(noise);
    tick();
    check("trail_data", tx_packet_data_out, last_data);
    check("trail_req", tx_req_out, 0);
    check("trail_busy", busy_out, 1);
    check("trail_ready", wr_ready_out, 0);
    check("trail_ovf", err_overflow_out, 0);
    tx_packet_data_rdy_in = 1'b0;
    tx_complete_in = 1'b1;
    junk(noise);
    tick();
    frames = frames + 16'd1;
    tx_complete_in = 1'b0;
    wr_en_in = 1'b0;
    wr_last_in = 1'b0;
    check_idle();
    check("done_ovf", err_overflow_out, 0);
  endtask

  initial begin
    #2;
    check_idle();
    check("rst_ovf", err_overflow_out, 0);
    tick();
    Reset = 1'b0;
    tick();

    // single word
    frame_data[0] = 16'hA55A;
    write_frame(1);
    drain(-1, 0, 1'b0);
    check("single_data", tx_packet_data_out, 16'hA55A);
    finish_frame(1'b0);

    // multi-word, consecutive pops
    for (int i = 0; i < 4; i++) frame_data[i] = 16'(i + 1);
    write_frame(4);
    drain(-1, 0, 1'b0);
    finish_frame(1'b0);

    // overflow: five words into a four-word buffer
    for (int i = 0; i < 5; i++) frame_data[i] = 16'h1000 + 16'(i);
    write_frame(5);
    tick();
    check("ovf_once", err_overflow_out, 0);
    check("ovf_send", tx_req_out, 1);
    drain(-1, 1, 1'b0);
    finish_frame(1'b0);

    // pop and completion strobes while idle are ignored
    tx_packet_data_rdy_in = 1'b1;
    tx_complete_in = 1'b1;
    tick();
    tx_packet_data_rdy_in = 1'b0;
    tx_complete_in = 1'b0;
    check_idle();

    // randomized frames with stray writes/completions during SEND and WAIT_DONE
    for (int f = 0; f < 25; f++) begin
      int n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) frame_data[i] = 16'($urandom);
      write_frame(n);
      drain(-1, 2, 1'b1);
      finish_frame(1'b1);
    end

    // reset mid-SEND after two of four pops
    for (int i = 0; i < 4; i++) frame_data[i] = 16'h2000 + 16'(i);
    write_frame(4);
    drain(2, 0, 1'b0);
    #2;
    Reset = 1'b1;
    #1;
    q.delete();
    last_data = 16'h0000;
    frames = 16'h0000;
    check_idle();
    check("rst_ovf2", err_overflow_out, 0);
    tick();
    Reset = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) frame_data[i] = 16'h3000 + 16'(i);
    write_frame(3);
    drain(-1, 1, 1'b0);
    finish_frame(1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
